// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage owning the PC, IF/ID register, and fetch counter
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);
  logic [31:0] pc;
  logic [31:0] pc_next;
  assign pc_next   = pc + 32'(PC_STEP);
  assign imem_addr = pc;
  // PC and IF/ID update: reset beats redirect (squash), redirect beats stall (hold)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc          <= {redirect_target[31:2], 2'b00};
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_next;
      if_id_instr <= imem_data;
      if_id_pc4   <= pc_next;
      if_id_valid <= 1'b1;
      fetch_count <= (fetch_count == '1) ? fetch_count : fetch_count + 32'd1;
    end
  end
endmodule
